// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, access
// sizes, RISC-V load/store funct3 encodings and a size-to-byte-count helper.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;
    localparam logic [2:0] F3_LDU = 3'b111;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    function automatic logic [3:0] bytes_of(input size_t sz);
        case (sz)
            SZ_B:    bytes_of = 4'd1;
            SZ_H:    bytes_of = 4'd2;
            SZ_W:    bytes_of = 4'd4;
            default: bytes_of = 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: byte strobes and shifted store data, plus
// load extraction with sign or zero extension.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [$clog2(XLEN/8)-1:0] offset,
    input  size_t                     size,
    input  logic                      is_unsigned,
    input  logic [XLEN-1:0]           wdata_in,
    input  logic [XLEN-1:0]           rdata_in,
    output logic [XLEN/8-1:0]         wstrb,
    output logic [XLEN-1:0]           wdata_out,
    output logic [XLEN-1:0]           rdata_out
);
    localparam int NB = XLEN / 8;

    logic [NB-1:0]   mask;
    logic [XLEN-1:0] shifted;
    logic            sgn;
    int              nbytes;
    int              nbits;

    always_comb begin
        nbytes = int'(bytes_of(size));
        nbits  = 8 * nbytes;
        // A doubleword on a 32-bit build is rejected upstream; clamp to stay in range.
        if (nbits > XLEN) nbits = XLEN;

        mask = '0;
        for (int i = 0; i < NB; i++) begin
            mask[i] = (i < nbytes);
        end
        wstrb     = mask << offset;
        wdata_out = wdata_in << {offset, 3'b000};

        shifted = rdata_in >> {offset, 3'b000};
        sgn     = 1'b0;
        for (int i = 0; i < XLEN; i++) begin
            if (i == nbits - 1) sgn = shifted[i];
        end
        for (int i = 0; i < XLEN; i++) begin
            rdata_out[i] = (i < nbits) ? shifted[i] : (~is_unsigned & sgn);
        end
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: valid/ready request/response engine between the core and a
// variable-latency data memory. Macro LSU_MISALIGN_TRAP_EN traps misaligned accesses.
module lsu
    import lsu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_func3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_write,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [XLEN-1:0]   mem_req_wdata,
    output logic [XLEN/8-1:0] mem_req_wstrb,
    input  logic              mem_resp_valid,
    input  logic [XLEN-1:0]   mem_resp_rdata,
    input  logic              mem_resp_err
);
    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);

    state_t            state_q, state_d;
    logic              write_q;
    logic [2:0]        func3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [OW-1:0]     off_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   rdata_q;
    logic              err_q;

    size_t             req_size;
    logic [OW-1:0]     req_off;
    logic [OW-1:0]     size_mask;
    logic [OW-1:0]     off_acc;
    logic              illegal;
    logic              reject;

    logic [NB-1:0]     al_wstrb;
    logic [XLEN-1:0]   al_wdata;
    logic [XLEN-1:0]   al_rdata;

    assign req_size  = size_t'(req_func3[1:0]);
    assign req_off   = req_addr[OW-1:0];
    assign size_mask = OW'(bytes_of(req_size) - 4'd1);
    assign illegal   = ((req_size == SZ_D) && (XLEN == 32))
                     || (req_write && req_func3[2])
                     || (!req_write && (req_func3 == F3_LDU));

`ifdef LSU_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = |(req_off & size_mask);
    assign reject     = illegal || misaligned;
    assign off_acc    = req_off;
`else
    assign reject     = illegal;
    assign off_acc    = req_off & ~size_mask;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (req_valid)      state_d = reject ? ST_RESP : ST_ISSUE;
            ST_ISSUE: if (mem_req_ready)  state_d = ST_WAIT;
            ST_WAIT:  if (mem_resp_valid) state_d = ST_RESP;
            ST_RESP:  if (resp_ready)     state_d = ST_IDLE;
            default:                      state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            write_q <= 1'b0;
            func3_q <= '0;
            addr_q  <= '0;
            off_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (state_q == ST_IDLE && req_valid) begin
            write_q <= req_write;
            func3_q <= req_func3;
            addr_q  <= {req_addr[ADDR_W-1:OW], {OW{1'b0}}};
            off_q   <= off_acc;
            wdata_q <= req_wdata;
            rdata_q <= '0;
            err_q   <= reject;
        end else if (state_q == ST_WAIT && mem_resp_valid) begin
            rdata_q <= mem_resp_rdata;
            err_q   <= mem_resp_err;
        end
    end

    lsu_align #(.XLEN(XLEN)) u_align (
        .offset      (off_q),
        .size        (size_t'(func3_q[1:0])),
        .is_unsigned (func3_q[2]),
        .wdata_in    (wdata_q),
        .rdata_in    (rdata_q),
        .wstrb       (al_wstrb),
        .wdata_out   (al_wdata),
        .rdata_out   (al_rdata)
    );

    // Everything below decodes from state and latched fields only.
    assign req_ready     = (state_q == ST_IDLE);
    assign mem_req_valid = (state_q == ST_ISSUE);
    assign mem_req_write = mem_req_valid && write_q;
    assign mem_req_addr  = mem_req_valid ? addr_q : '0;
    assign mem_req_wdata = mem_req_valid ? al_wdata : '0;
    assign mem_req_wstrb = (mem_req_valid && write_q) ? al_wstrb : '0;
    assign resp_valid    = (state_q == ST_RESP);
    assign resp_err      = resp_valid && err_q;
    assign resp_rdata    = (resp_valid && !err_q && !write_q) ? al_rdata : '0;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: one XLEN=32 and one XLEN=64 instance behind a shared
// stimulus/memory model, with a scoreboard of expected responses.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel64;
    logic        req_valid, req_write, resp_ready;
    logic [2:0]  req_func3;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic        mem_req_ready, mem_resp_valid, mem_resp_err;
    logic [63:0] mem_resp_rdata;

    logic        r32_req_ready, r32_resp_valid, r32_resp_err, r32_mem_req_valid, r32_mem_req_write;
    logic [31:0] r32_resp_rdata, r32_mem_req_addr, r32_mem_req_wdata;
    logic [3:0]  r32_mem_req_wstrb;
    logic        r64_req_ready, r64_resp_valid, r64_resp_err, r64_mem_req_valid, r64_mem_req_write;
    logic [63:0] r64_resp_rdata, r64_mem_req_wdata;
    logic [31:0] r64_mem_req_addr;
    logic [7:0]  r64_mem_req_wstrb;

    logic        o_req_ready, o_resp_valid, o_resp_err, o_mem_req_valid, o_mem_req_write;
    logic [63:0] o_resp_rdata, o_mem_req_wdata;
    logic [31:0] o_mem_req_addr;
    logic [7:0]  o_mem_req_wstrb;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sb_q[$];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lsu #(.XLEN(32), .ADDR_W(32)) u_dut32 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid & ~sel64), .req_ready(r32_req_ready),
        .req_write(req_write), .req_func3(req_func3), .req_addr(req_addr),
        .req_wdata(req_wdata[31:0]),
        .resp_valid(r32_resp_valid), .resp_ready(resp_ready & ~sel64),
        .resp_rdata(r32_resp_rdata), .resp_err(r32_resp_err),
        .mem_req_valid(r32_mem_req_valid), .mem_req_ready(mem_req_ready & ~sel64),
        .mem_req_write(r32_mem_req_write), .mem_req_addr(r32_mem_req_addr),
        .mem_req_wdata(r32_mem_req_wdata), .mem_req_wstrb(r32_mem_req_wstrb),
        .mem_resp_valid(mem_resp_valid & ~sel64), .mem_resp_rdata(mem_resp_rdata[31:0]),
        .mem_resp_err(mem_resp_err)
    );

    lsu #(.XLEN(64), .ADDR_W(32)) u_dut64 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid & sel64), .req_ready(r64_req_ready),
        .req_write(req_write), .req_func3(req_func3), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(r64_resp_valid), .resp_ready(resp_ready & sel64),
        .resp_rdata(r64_resp_rdata), .resp_err(r64_resp_err),
        .mem_req_valid(r64_mem_req_valid), .mem_req_ready(mem_req_ready & sel64),
        .mem_req_write(r64_mem_req_write), .mem_req_addr(r64_mem_req_addr),
        .mem_req_wdata(r64_mem_req_wdata), .mem_req_wstrb(r64_mem_req_wstrb),
        .mem_resp_valid(mem_resp_valid & sel64), .mem_resp_rdata(mem_resp_rdata),
        .mem_resp_err(mem_resp_err)
    );

    assign o_req_ready     = sel64 ? r64_req_ready     : r32_req_ready;
    assign o_resp_valid    = sel64 ? r64_resp_valid    : r32_resp_valid;
    assign o_resp_err      = sel64 ? r64_resp_err      : r32_resp_err;
    assign o_mem_req_valid = sel64 ? r64_mem_req_valid : r32_mem_req_valid;
    assign o_mem_req_write = sel64 ? r64_mem_req_write : r32_mem_req_write;
    assign o_resp_rdata    = sel64 ? r64_resp_rdata    : {32'h0, r32_resp_rdata};
    assign o_mem_req_wdata = sel64 ? r64_mem_req_wdata : {32'h0, r32_mem_req_wdata};
    assign o_mem_req_addr  = sel64 ? r64_mem_req_addr  : r32_mem_req_addr;
    assign o_mem_req_wstrb = sel64 ? r64_mem_req_wstrb : {4'h0, r32_mem_req_wstrb};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one request, play the memory, and check every cycle until the response handshake.
    task automatic access(input string name, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [63:0] wd,
                          input logic [63:0] word, input logic merr,
                          input bit exp_mem, input logic [31:0] exp_maddr,
                          input logic [7:0] exp_wstrb, input logic [63:0] exp_wdata,
                          input logic [63:0] exp_rdata, input logic exp_err,
                          input int mem_stall, input int resp_stall);
        exp_t e;
        int   k, msc, rsc;
        bit   pend, seen_mem, seen_resp, done;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.lat   = exp_mem ? 3 + mem_stall : 1;
        sb_q.push_back(e);

        @(negedge clk);
        check({name, ".req_ready_idle"}, 64'(o_req_ready), 64'(1));
        req_valid = 1'b1; req_write = wr; req_func3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        k = 0; msc = 0; rsc = 0; pend = 0; seen_mem = 0; seen_resp = 0; done = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
            req_valid = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
            mem_resp_rdata = '0; mem_resp_err = 1'b0; resp_ready = 1'b0;
            if (pend) begin
                mem_resp_valid = 1'b1; mem_resp_rdata = word; mem_resp_err = merr; pend = 0;
            end
            check({name, ".req_ready_busy"}, 64'(o_req_ready), 64'(0));
            if (o_mem_req_valid) begin
                if (!seen_mem) check({name, ".mem_req_valid"}, 64'(1), 64'(exp_mem));
                seen_mem = 1;
                check({name, ".mem_write"}, 64'(o_mem_req_write), 64'(wr));
                check({name, ".mem_addr"},  64'(o_mem_req_addr),  64'(exp_maddr));
                check({name, ".mem_wstrb"}, 64'(o_mem_req_wstrb), 64'(exp_wstrb));
                check({name, ".mem_wdata"}, o_mem_req_wdata, exp_wdata);
                if (msc == mem_stall) begin
                    mem_req_ready = 1'b1; pend = 1;
                end else msc++;
            end
            if (o_resp_valid && sb_q.size() > 0) begin
                if (!seen_resp) begin
                    seen_resp = 1;
                    check({name, ".latency"}, 64'(k), 64'(sb_q[0].lat));
                end
                check({name, ".rdata"}, o_resp_rdata, sb_q[0].rdata);
                check({name, ".err"}, 64'(o_resp_err), 64'(sb_q[0].err));
                if (rsc == resp_stall) begin
                    resp_ready = 1'b1; done = 1;
                end else rsc++;
            end
        end
        check({name, ".completed"}, 64'(done), 64'(1));
        check({name, ".mem_seen"}, 64'(seen_mem), 64'(exp_mem));
        if (done && sb_q.size() > 0) void'(sb_q.pop_front());
        @(negedge clk);
        resp_ready = 1'b0;
        check({name, ".req_ready_after"},  64'(o_req_ready),  64'(1));
        check({name, ".resp_valid_after"}, 64'(o_resp_valid), 64'(0));
    endtask

    initial begin
        rst = 1'b0; sel64 = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_func3 = '0; req_addr = '0; req_wdata = '0;
        resp_ready = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        mem_resp_rdata = '0; mem_resp_err = 1'b0;

        repeat (2) @(negedge clk);
        check("rst.req_ready",     64'(o_req_ready),     64'(1));
        check("rst.resp_valid",    64'(o_resp_valid),    64'(0));
        check("rst.mem_req_valid", 64'(o_mem_req_valid), 64'(0));
        check("rst.mem_addr",      64'(o_mem_req_addr),  64'(0));
        check("rst.mem_wstrb",     64'(o_mem_req_wstrb), 64'(0));
        check("rst.resp_rdata",    o_resp_rdata,         64'(0));
        check("rst.resp_err",      64'(o_resp_err),      64'(0));
        rst = 1'b1;

        // XLEN = 32
        access("sw", 1, 3'b010, 32'h8000_0004, 64'hDEAD_BEEF, 64'h0, 0,
               1, 32'h8000_0004, 8'h0F, 64'hDEAD_BEEF, 64'h0, 0, 0, 0);
        access("lb", 0, 3'b000, 32'h8000_0003, 64'h0, 64'h80FF_7F01, 0,
               1, 32'h8000_0000, 8'h00, 64'h0, 64'hFFFF_FF80, 0, 0, 0);
        access("lbu", 0, 3'b100, 32'h8000_0003, 64'h0, 64'h80FF_7F01, 0,
               1, 32'h8000_0000, 8'h00, 64'h0, 64'h0000_0080, 0, 0, 0);
        access("sh", 1, 3'b001, 32'h8000_0002, 64'h0000_1234, 64'h0, 0,
               1, 32'h8000_0000, 8'h0C, 64'h1234_0000, 64'h0, 0, 0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        access("lw_mis", 0, 3'b010, 32'h8000_0002, 64'h0, 64'h1122_3344, 0,
               0, 32'h0, 8'h00, 64'h0, 64'h0, 1, 0, 0);
`else
        access("lw_mis", 0, 3'b010, 32'h8000_0002, 64'h0, 64'h1122_3344, 0,
               1, 32'h8000_0000, 8'h00, 64'h0, 64'h1122_3344, 0, 0, 0);
`endif
        access("lh", 0, 3'b001, 32'h8000_0006, 64'h0, 64'h8001_5555, 0,
               1, 32'h8000_0004, 8'h00, 64'h0, 64'hFFFF_8001, 0, 0, 0);
        access("lhu", 0, 3'b101, 32'h8000_0006, 64'h0, 64'h8001_5555, 0,
               1, 32'h8000_0004, 8'h00, 64'h0, 64'h0000_8001, 0, 0, 0);
        access("ld32", 0, 3'b011, 32'h8000_0000, 64'h0, 64'h0, 0,
               0, 32'h0, 8'h00, 64'h0, 64'h0, 1, 0, 0);
        access("sbu", 1, 3'b100, 32'h8000_0000, 64'h55, 64'h0, 0,
               0, 32'h0, 8'h00, 64'h0, 64'h0, 1, 0, 0);
        access("ldu32", 0, 3'b111, 32'h8000_0000, 64'h0, 64'h0, 0,
               0, 32'h0, 8'h00, 64'h0, 64'h0, 1, 0, 0);
        access("sb_bp", 1, 3'b000, 32'h8000_0001, 64'hA5, 64'h0, 0,
               1, 32'h8000_0000, 8'h02, 64'h0000_A500, 64'h0, 0, 4, 3);
        access("lw_berr", 0, 3'b010, 32'h8000_0008, 64'h0, 64'hFFFF_FFFF, 1,
               1, 32'h8000_0008, 8'h00, 64'h0, 64'h0, 1, 0, 0);

        // Reset while waiting for the memory response
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_func3 = 3'b010; req_addr = 32'h8000_0010;
        @(negedge clk);
        req_valid = 1'b0;
        check("rstw.issue", 64'(o_mem_req_valid), 64'(1));
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        check("rstw.wait_mem_valid", 64'(o_mem_req_valid), 64'(0));
        check("rstw.wait_req_ready", 64'(o_req_ready),     64'(0));
        #1 rst = 1'b0;
        #1;
        check("rstw.req_ready",  64'(o_req_ready),     64'(1));
        check("rstw.mem_valid",  64'(o_mem_req_valid), 64'(0));
        check("rstw.resp_valid", 64'(o_resp_valid),    64'(0));
        check("rstw.mem_addr",   64'(o_mem_req_addr),  64'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        mem_resp_valid = 1'b1; mem_resp_rdata = 64'h1234_5678;
        @(negedge clk);
        mem_resp_valid = 1'b0; mem_resp_rdata = '0;
        check("stale.resp_valid", 64'(o_resp_valid), 64'(0));
        check("stale.req_ready",  64'(o_req_ready),  64'(1));
        access("lw_after_rst", 0, 3'b010, 32'h8000_0010, 64'h0, 64'hCAFE_F00D, 0,
               1, 32'h8000_0010, 8'h00, 64'h0, 64'hCAFE_F00D, 0, 0, 0);

        // XLEN = 64
        @(negedge clk);
        sel64 = 1'b1;
        access("lwu64", 0, 3'b110, 32'h0000_1004, 64'h0, 64'h89AB_CDEF_0123_4567, 0,
               1, 32'h0000_1000, 8'h00, 64'h0, 64'h0000_0000_89AB_CDEF, 0, 0, 0);
        access("lw64", 0, 3'b010, 32'h0000_1004, 64'h0, 64'h89AB_CDEF_0123_4567, 0,
               1, 32'h0000_1000, 8'h00, 64'h0, 64'hFFFF_FFFF_89AB_CDEF, 0, 0, 0);
        access("ld64_berr", 0, 3'b011, 32'h0000_1000, 64'h0, 64'h89AB_CDEF_0123_4567, 1,
               1, 32'h0000_1000, 8'h00, 64'h0, 64'h0, 1, 0, 0);
        access("sd64", 1, 3'b011, 32'h0000_1008, 64'h0123_4567_89AB_CDEF, 64'h0, 0,
               1, 32'h0000_1008, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0, 0, 0, 0);
        access("lb64", 0, 3'b000, 32'h0000_1007, 64'h0, 64'h89AB_CDEF_0123_4567, 0,
               1, 32'h0000_1000, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FF89, 0, 0, 0);
        access("ldu64", 0, 3'b111, 32'h0000_1000, 64'h0, 64'h0, 0,
               0, 32'h0, 8'h00, 64'h0, 64'h0, 1, 0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        access("lw64_mis", 0, 3'b010, 32'h0000_1006, 64'h0, 64'h89AB_CDEF_0123_4567, 0,
               0, 32'h0, 8'h00, 64'h0, 64'h0, 1, 0, 0);
`else
        access("lw64_mis", 0, 3'b010, 32'h0000_1006, 64'h0, 64'h89AB_CDEF_0123_4567, 0,
               1, 32'h0000_1000, 8'h00, 64'h0, 64'hFFFF_FFFF_89AB_CDEF, 0, 0, 0);
`endif

        check("scoreboard_empty", 64'(sb_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/lsu.md
# lsu

Parametrised load/store unit for the multicycle RV core: it replaces the single-cycle, always-ready data-memory path with a valid/ready request/response engine. It sits between the execute/write-back stages (core side) and the data memory or bus (memory side), and supports XLEN 32 or 64 and memories with arbitrary latency. It generates byte strobes, aligns store data, and extracts plus sign- or zero-extends load data for b/h/w/d and the unsigned variants.

## Interface
- XLEN, 32: data width, 32 or 64; NB = XLEN/8, OW = log2(NB).
- ADDR_W, 32: address width.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid / req_ready  in / out  1  core request handshake.
- req_write  in  1  1 = store, 0 = load.
- req_func3  in  3  RISC-V funct3 (size = [1:0], unsigned = [2]).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data, LSB-justified.
- resp_valid / resp_ready  out / in  1  core response handshake.
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- resp_err  out  1  access fault, misalignment, or illegal funct3.
- mem_req_valid / mem_req_ready  out / in  1  memory request handshake.
- mem_req_write  out  1  store flag.
- mem_req_addr  out  ADDR_W  req_addr with low OW bits cleared.
- mem_req_wdata  out  XLEN  req_wdata << (8*offset).
- mem_req_wstrb  out  NB  ((1<<bytes)-1) << offset; 0 for loads.
- mem_resp_valid  in  1  memory response (no ready; always accepted in WAIT).
- mem_resp_rdata  in  XLEN  aligned memory word.
- mem_resp_err  in  1  bus error.

## Operation
- States: IDLE, ISSUE, WAIT, RESP. req_ready = 1 only in IDLE.
- IDLE: on req_valid, latch the request. Legal -> ISSUE. Illegal or trapped-misaligned -> RESP with err = 1, and no memory request is issued.
- Illegal funct3: size 3 when XLEN = 32; store with func3[2] = 1; load 3'b111 (LDU).
- ISSUE: mem_req_valid = 1, with all mem_req_* held stable until mem_req_ready. On the handshake: loads and stores -> WAIT.
- WAIT: on mem_resp_valid, capture the data and the error -> RESP.
- RESP: resp_valid = 1, outputs stable until resp_ready, then IDLE.
- Load extract: word >> (8*offset), truncated to the size, then sign-extended (func3[2] = 0) or zero-extended.
- Store responses: rdata = 0. mem_resp_err = 1 forces rdata = 0 and err = 1.
- mem_resp_valid outside WAIT is ignored. This includes a stale response after reset.
- Reset (async, any state): state IDLE, and every output 0 except req_ready = 1. Latched request cleared.

## Timing
- Minimum load/store latency, with mem ready and a next-cycle response: acceptance edge E0 -> mem_req_valid in cycle E0+1 -> resp_valid in cycle E0+3.
- The memory must not assert mem_resp_valid in the same cycle as the mem_req handshake.
- Error short path: resp_valid in cycle E0+1.
- Throughput is one access in flight. The next request can be accepted in the cycle after the resp handshake.
- All outputs are registered or decoded from state/latched fields. There is no combinational path from req_* or mem_* inputs to outputs.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: offset not a multiple of the size gives err = 1 via the short path, with no memory access.
- Undefined: the offset is masked down to size alignment and the access proceeds normally with err = 0. For example, lw at 0x...2 reads 0x...0.

## Structure
- lsu_pkg holds:
  - state enum;
  - funct3 constants LB/LH/LW/LD/LBU/LHU/LWU and SB/SH/SW/SD;
  - size enum;
  - function bytes_of(size).
- The sub-module lsu_align is purely combinational. Given offset, size, and unsigned, it produces wstrb, shifted wdata, and extended rdata.

## Test plan
- XLEN=32, SW 0x80000004 with data 0xDEADBEEF, mem always ready, response next cycle -> mem addr 0x80000004, wstrb 4'b1111, wdata 0xDEADBEEF; resp_valid at E0+3, err 0.
- LB at 0x80000003, mem returns 0x80FF7F01 -> rdata 0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH 0x80000002 with data 0x00001234 -> wstrb 4'b1100, wdata 0x12340000. LW 0x80000002:
  - with LSU_MISALIGN_TRAP_EN -> err 1 at E0+1 and mem_req_valid never asserted;
  - without it -> mem addr 0x80000000, err 0.
- Backpressure: mem_req_ready low for 4 cycles, then resp_ready low for 3 cycles -> mem_req_*/resp_* stable throughout and req_ready = 0; total latency 3+4+3.
- Drive rst low in WAIT -> outputs cleared immediately. A later mem_resp_valid is ignored, and a new request completes normally.
- XLEN=64, mem returns 0x89ABCDEF_01234567:
  - LWU at offset 4 -> 0x00000000_89ABCDEF;
  - LW at offset 4 -> 0xFFFFFFFF_89ABCDEF;
  - mem_resp_err = 1 -> err 1, rdata 0.
